ntt_stage_sequencer: RTL and testbench

Parametrised successor to the fixed 8-stage NTT fold controller. It sequences all butterflies of an N-point radix-2 NTT across LANES parallel butterfly units, generating per-lane coefficient and twiddle addresses with correct group/offset mapping. It supports forward (Cooley-Tukey, DIT) and inverse (Gentleman-Sande, DIF) modes, a valid/ready issue handshake, a configurable inter-stage drain gap and synchronous abort. It sits between the NTT command front-end and the butterfly datapath/coefficient RAM.

---
 rtl/ntt_pkg.sv | 41 ++++
 rtl/ntt_lane_addr_gen.sv | 39 +++
 rtl/ntt_stage_sequencer.sv | 168 ++++++++++++++++
 tb/tb_ntt_stage_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared types and helpers for the NTT stage sequencer.
package ntt_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } ntt_seq_state_t;

  // Working width of the butterfly mapper; transforms up to N = 2^15 are supported.
  localparam int unsigned NTT_MAP_W = 16;

  typedef struct packed {
    logic [NTT_MAP_W-1:0] a;
    logic [NTT_MAP_W-1:0] b;
    logic [NTT_MAP_W-1:0] k;
  } ntt_bf_t;

  // Beats needed to cover the N/2 butterflies of one stage.
  function automatic int unsigned ntt_beats(input int unsigned n, input int unsigned lanes);
    return n / (2 * lanes);
  endfunction

  // Stage port width: max(1, clog2(LOGN)).
  function automatic int unsigned ntt_stage_w(input int unsigned logn);
    return (logn <= 2) ? 1 : $clog2(logn);
  endfunction

  // Butterfly j at shift h: group g = j>>h, offset k, inputs a and b = a + 2^h.
  function automatic ntt_bf_t ntt_bf_map(input logic [NTT_MAP_W-1:0] j, input logic [4:0] h);
    ntt_bf_t              r;
    logic [NTT_MAP_W-1:0] span;
    span = NTT_MAP_W'(1) << h;
    r.k  = j & (span - NTT_MAP_W'(1));
    r.a  = ((j >> h) << (h + 5'd1)) + r.k;
    r.b  = r.a + span;
    return r;
  endfunction

endpackage

// File: rtl/ntt_lane_addr_gen.sv
// Combinational coefficient/twiddle address mapping for one butterfly lane.
module ntt_lane_addr_gen
  import ntt_pkg::*;
#(
  parameter int unsigned N      = 256,
  parameter int unsigned LOGN   = $clog2(N),
  parameter int unsigned ADDR_W = $clog2(N)
) (
  input  logic [ADDR_W-1:0] j,
  input  logic [4:0]        h,
  input  logic              mode_inv,
  output logic [ADDR_W-1:0] a,
  output logic [ADDR_W-1:0] b,
  output logic [ADDR_W-1:0] tw
);

  // Inverse twiddles live in the upper half of the ROM.
  localparam logic [ADDR_W-1:0] TW_OFS = ADDR_W'(N / 2);

  ntt_bf_t              bf;
  logic [4:0]           tw_sh;
  logic [NTT_MAP_W-1:0] tw_full;
  logic                 unused_hi;

  // Map the butterfly index to its two inputs and twiddle index.
  always_comb begin
    bf      = ntt_bf_map(NTT_MAP_W'(j), h);
    tw_sh   = 5'(LOGN - 1) - h;
    tw_full = bf.k << tw_sh;
    a       = bf.a[ADDR_W-1:0];
    b       = bf.b[ADDR_W-1:0];
    tw      = tw_full[ADDR_W-1:0] + (mode_inv ? TW_OFS : '0);
  end

  // Results are always below N, so the upper mapper bits are zero.
  assign unused_hi = ^{bf.a[NTT_MAP_W-1:ADDR_W], bf.b[NTT_MAP_W-1:ADDR_W],
                       tw_full[NTT_MAP_W-1:ADDR_W]};

endmodule

// File: rtl/ntt_stage_sequencer.sv
// Sequences every butterfly of an N-point radix-2 NTT across LANES butterfly units.
module ntt_stage_sequencer
  import ntt_pkg::*;
#(
  parameter int unsigned N         = 256,
  parameter int unsigned LOGN      = $clog2(N),
  parameter int unsigned LANES     = 2,
  parameter int unsigned DRAIN_CYC = 4,
  parameter int unsigned ADDR_W    = $clog2(N),
  parameter int unsigned STAGE_W   = ntt_stage_w(LOGN)
) (
  input  logic                      clk_core,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      inverse,
  input  logic                      abort,
  output logic                      busy,
  output logic                      done,
  output logic                      mode_inv,
  output logic                      issue_valid,
  input  logic                      issue_ready,
  output logic                      last_in_stage,
  output logic [STAGE_W-1:0]        stage,
  output logic [LANES*ADDR_W-1:0]   coeff_a_addr,
  output logic [LANES*ADDR_W-1:0]   coeff_b_addr,
  output logic [LANES*ADDR_W-1:0]   tw_addr
);

  localparam int unsigned       BEATS      = ntt_beats(N, LANES);
  localparam logic [ADDR_W-1:0] LAST_BASE  = ADDR_W'((BEATS - 1) * LANES);
  localparam logic [STAGE_W-1:0] LAST_STG  = STAGE_W'(LOGN - 1);
  localparam int unsigned       DW         = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
  localparam logic [DW-1:0]     DRAIN_LAST = DW'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

  ntt_seq_state_t     state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [STAGE_W-1:0] stage_q, stage_d;
  logic [DW-1:0]      drain_q, drain_d;
  logic               mode_q, mode_d;

  logic                    busy_q, done_q, valid_q, last_q;
  logic [LANES*ADDR_W-1:0] a_q, b_q, tw_q;
  logic [LANES*ADDR_W-1:0] a_nxt, b_nxt, tw_nxt;
  logic [4:0]              h_nxt;
  logic                    accept;

  assign accept = valid_q && issue_ready;

  // Next-state logic for the FSM and its base/stage/drain counters; abort overrides all.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    stage_d = stage_q;
    drain_d = drain_q;
    mode_d  = mode_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          mode_d  = inverse;
          base_d  = '0;
          stage_d = '0;
        end
      end
      StRun: begin
        if (accept) begin
          if (base_q == LAST_BASE) begin
            base_d = '0;
            if (DRAIN_CYC > 0) begin
              state_d = StDrain;
              drain_d = '0;
            end else if (stage_q == LAST_STG) begin
              state_d = StDone;
            end else begin
              stage_d = stage_q + STAGE_W'(1);
            end
          end else begin
            base_d = base_q + ADDR_W'(LANES);
          end
        end
      end
      StDrain: begin
        if (drain_q == DRAIN_LAST) begin
          if (stage_q == LAST_STG) begin
            state_d = StDone;
          end else begin
            state_d = StRun;
            stage_d = stage_q + STAGE_W'(1);
          end
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort) begin
      state_d = StIdle;
      base_d  = '0;
      stage_d = '0;
      drain_d = '0;
    end
  end

  // Addresses are computed from next-state values so they register alongside issue_valid.
  assign h_nxt = mode_d ? (5'(LOGN - 1) - 5'(stage_d)) : 5'(stage_d);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [ADDR_W-1:0] j;
    assign j = base_d + ADDR_W'(l);
    ntt_lane_addr_gen #(
      .N      (N),
      .LOGN   (LOGN),
      .ADDR_W (ADDR_W)
    ) u_gen (
      .j        (j),
      .h        (h_nxt),
      .mode_inv (mode_d),
      .a        (a_nxt[l*ADDR_W +: ADDR_W]),
      .b        (b_nxt[l*ADDR_W +: ADDR_W]),
      .tw       (tw_nxt[l*ADDR_W +: ADDR_W])
    );
  end

  // State, counters and registered outputs; addresses only update when a beat is presented.
  always_ff @(posedge clk_core) begin
    if (rst) begin
      state_q <= StIdle;
      base_q  <= '0;
      stage_q <= '0;
      drain_q <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      tw_q    <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      stage_q <= stage_d;
      drain_q <= drain_d;
      mode_q  <= mode_d;
      busy_q  <= (state_d == StRun) || (state_d == StDrain);
      done_q  <= (state_d == StDone);
      valid_q <= (state_d == StRun);
      last_q  <= (state_d == StRun) && (base_d == LAST_BASE);
      if (state_d == StRun) begin
        a_q  <= a_nxt;
        b_q  <= b_nxt;
        tw_q <= tw_nxt;
      end
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign mode_inv      = mode_q;
  assign issue_valid   = valid_q;
  assign last_in_stage = last_q;
  assign stage         = stage_q;
  assign coeff_a_addr  = a_q;
  assign coeff_b_addr  = b_q;
  assign tw_addr       = tw_q;

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Scoreboard bench: default configuration plus an N=16, LANES=4, no-drain instance.
module tb_ntt_stage_sequencer;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] tw;
    logic        last;
    int          stage;
  } beat_t;

  logic clk = 1'b0;
  logic rst;

  logic        start0, inv0, abort0, ready0;
  logic        busy0, done0, minv0, valid0, last0;
  logic [2:0]  stage0;
  logic [15:0] a0, b0, tw0;

  logic        start1, inv1, abort1, ready1;
  logic        busy1, done1, minv1, valid1, last1;
  logic [1:0]  stage1;
  logic [15:0] a1, b1, tw1;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    start_cyc = 0;
  int    spot = 0;
  int    done_at0, done_cnt0, vcnt0;
  int    done_at1, done_cnt1;
  int    cov [4][16];
  beat_t q0[$];
  beat_t q1[$];

  ntt_stage_sequencer u_dut0 (
    .clk_core      (clk),
    .rst           (rst),
    .start         (start0),
    .inverse       (inv0),
    .abort         (abort0),
    .busy          (busy0),
    .done          (done0),
    .mode_inv      (minv0),
    .issue_valid   (valid0),
    .issue_ready   (ready0),
    .last_in_stage (last0),
    .stage         (stage0),
    .coeff_a_addr  (a0),
    .coeff_b_addr  (b0),
    .tw_addr       (tw0)
  );

  ntt_stage_sequencer #(
    .N         (16),
    .LANES     (4),
    .DRAIN_CYC (0)
  ) u_dut1 (
    .clk_core      (clk),
    .rst           (rst),
    .start         (start1),
    .inverse       (inv1),
    .abort         (abort1),
    .busy          (busy1),
    .done          (done1),
    .mode_inv      (minv1),
    .issue_valid   (valid1),
    .issue_ready   (ready1),
    .last_in_stage (last1),
    .stage         (stage1),
    .coeff_a_addr  (a1),
    .coeff_b_addr  (b1),
    .tw_addr       (tw1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference mapping written with division/modulo on integer butterfly indices.
  function automatic beat_t model(input int n, input int lanes, input bit inv, input int s,
                                  input int beat);
    beat_t e;
    int logn, h, span, j, g, k, av;
    logn = $clog2(n);
    h    = inv ? (logn - 1 - s) : s;
    span = 1 << h;
    e.a  = '0;
    e.b  = '0;
    e.tw = '0;
    for (int l = 0; l < lanes; l++) begin
      j    = beat * lanes + l;
      g    = j / span;
      k    = j % span;
      av   = g * 2 * span + k;
      e.a  = e.a  | (16'(av) << (l * logn));
      e.b  = e.b  | (16'(av + span) << (l * logn));
      e.tw = e.tw | (16'(k * (n / (2 * span)) + (inv ? n / 2 : 0)) << (l * logn));
    end
    e.last  = (beat == n / (2 * lanes) - 1);
    e.stage = s;
    return e;
  endfunction

  // Default instance: compare presented beats against the queue head; pop on acceptance.
  always @(negedge clk) begin
    int    rel;
    beat_t e;
    if (!rst) begin
      rel = cyc - start_cyc;
      if (done0) begin
        done_cnt0++;
        done_at0 = rel;
      end
      if (valid0) begin
        vcnt0++;
        chk("dut0_beat_expected", 32'(q0.size() != 0), 32'd1);
        if (q0.size() != 0) begin
          e = q0[0];
          chk("dut0_a", 32'(a0), 32'(e.a));
          chk("dut0_b", 32'(b0), 32'(e.b));
          chk("dut0_tw", 32'(tw0), 32'(e.tw));
          chk("dut0_last", 32'(last0), 32'(e.last));
          chk("dut0_stage", 32'(stage0), 32'(e.stage));
          if (ready0) void'(q0.pop_front());
        end
      end
      if (spot == 1 && rel == 1) begin
        chk("fwd_beat1_a", 32'(a0), 32'h0200);
        chk("fwd_beat1_b", 32'(b0), 32'h0301);
        chk("fwd_beat1_tw", 32'(tw0), 32'h0000);
      end
      if (spot == 1 && rel == 69) begin
        chk("fwd_stg1_a", 32'(a0), 32'h0100);
        chk("fwd_stg1_b", 32'(b0), 32'h0302);
        chk("fwd_stg1_tw", 32'(tw0), 32'h4000);
      end
      if (spot == 2 && rel == 1) begin
        chk("inv_beat1_a", 32'(a0), 32'h0100);
        chk("inv_beat1_b", 32'(b0), 32'h8180);
        chk("inv_beat1_tw", 32'(tw0), 32'h8180);
        chk("inv_mode", 32'(minv0), 32'd1);
      end
      if (spot == 2 && rel == 477) begin
        chk("inv_stg7_a", 32'(a0), 32'h0200);
        chk("inv_stg7_b", 32'(b0), 32'h0301);
        chk("inv_stg7_tw", 32'(tw0), 32'h8080);
        chk("inv_stg7_mode", 32'(minv0), 32'd1);
      end
    end
  end

  // Small instance: scoreboard plus per-stage address coverage.
  always @(negedge clk) begin
    int    rel;
    beat_t e;
    if (!rst) begin
      rel = cyc - start_cyc;
      if (done1) begin
        done_cnt1++;
        done_at1 = rel;
      end
      if (valid1) begin
        chk("dut1_beat_expected", 32'(q1.size() != 0), 32'd1);
        if (q1.size() != 0) begin
          e = q1[0];
          chk("dut1_a", 32'(a1), 32'(e.a));
          chk("dut1_b", 32'(b1), 32'(e.b));
          chk("dut1_tw", 32'(tw1), 32'(e.tw));
          chk("dut1_last", 32'(last1), 32'(e.last));
          chk("dut1_stage", 32'(stage1), 32'(e.stage));
          if (ready1) begin
            for (int l = 0; l < 4; l++) begin
              cov[e.stage][a1[l*4 +: 4]]++;
              cov[e.stage][b1[l*4 +: 4]]++;
            end
            void'(q1.pop_front());
          end
        end
      end
    end
  end

  // One default-instance transform; entered and left just after a rising edge.
  task automatic run0(input bit inv, input int stall_at, input int abort_at, input int spur_a,
                      input int spur_b, input int limit, input int spot_sel);
    done_at0  = -1;
    done_cnt0 = 0;
    vcnt0     = 0;
    spot      = spot_sel;
    start_cyc = cyc;
    for (int s = 0; s < 8; s++)
      for (int bt = 0; bt < 64; bt++) q0.push_back(model(256, 2, inv, s, bt));
    start0 = 1'b1;
    inv0   = inv;
    @(posedge clk);
    #1;
    for (int rel = 1; rel <= limit; rel++) begin
      ready0 = !(stall_at >= 0 && rel >= stall_at && rel < stall_at + 3);
      abort0 = (rel == abort_at);
      start0 = (rel == spur_a) || (rel == spur_b);
      inv0   = start0 ? !inv : inv;
      @(negedge clk);
      if (abort_at >= 0 && rel == abort_at + 1) begin
        chk("abort_busy", 32'(busy0), 32'd0);
        chk("abort_valid", 32'(valid0), 32'd0);
        chk("abort_done", 32'(done0), 32'd0);
      end
      @(posedge clk);
      #1;
    end
    start0 = 1'b0;
    abort0 = 1'b0;
    ready0 = 1'b1;
    spot   = 0;
  endtask

  initial begin
    rst    = 1'b1;
    start0 = 1'b0; inv0 = 1'b0; abort0 = 1'b0; ready0 = 1'b1;
    start1 = 1'b0; inv1 = 1'b0; abort1 = 1'b0; ready1 = 1'b1;
    done_at0 = -1; done_cnt0 = 0; vcnt0 = 0;
    done_at1 = -1; done_cnt1 = 0;
    for (int s = 0; s < 4; s++)
      for (int x = 0; x < 16; x++) cov[s][x] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_mode", 32'(minv0), 32'd0);
    chk("rst_valid", 32'(valid0), 32'd0);
    chk("rst_last", 32'(last0), 32'd0);
    chk("rst_stage", 32'(stage0), 32'd0);
    chk("rst_addr", 32'({a0, b0}), 32'd0);
    chk("rst_tw", 32'(tw0), 32'd0);
    chk("rst1_busy", 32'(busy1), 32'd0);
    chk("rst1_valid", 32'(valid1), 32'd0);
    chk("rst1_addr", 32'({a1, b1}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Forward, ready held high.
    run0(1'b0, -1, -1, -1, -1, 560, 1);
    chk("fwd_done_cycle", 32'(done_at0), 32'd545);
    chk("fwd_done_count", 32'(done_cnt0), 32'd1);
    chk("fwd_valid_cycles", 32'(vcnt0), 32'd512);
    chk("fwd_queue_empty", 32'(q0.size()), 32'd0);
    chk("fwd_mode", 32'(minv0), 32'd0);

    // Inverse with ignored start pulses while busy and coincident with DONE.
    run0(1'b1, -1, -1, 10, 545, 560, 2);
    chk("inv_done_cycle", 32'(done_at0), 32'd545);
    chk("inv_done_count", 32'(done_cnt0), 32'd1);
    chk("inv_valid_cycles", 32'(vcnt0), 32'd512);
    chk("inv_queue_empty", 32'(q0.size()), 32'd0);
    chk("inv_mode_kept", 32'(minv0), 32'd1);
    chk("inv_idle_after", 32'(busy0), 32'd0);

    // Backpressure: ready low for three cycles at stage 2, beat 10.
    run0(1'b0, 147, -1, -1, -1, 560, 0);
    chk("bp_done_cycle", 32'(done_at0), 32'd548);
    chk("bp_valid_cycles", 32'(vcnt0), 32'd515);
    chk("bp_queue_empty", 32'(q0.size()), 32'd0);

    // Abort inside the stage-4 drain window, then a clean transform.
    run0(1'b0, -1, 338, -1, -1, 360, 0);
    chk("abort_no_done", 32'(done_cnt0), 32'd0);
    chk("abort_idle", 32'(busy0), 32'd0);
    q0.delete();
    run0(1'b0, -1, -1, -1, -1, 560, 0);
    chk("post_abort_done_cycle", 32'(done_at0), 32'd545);
    chk("post_abort_queue_empty", 32'(q0.size()), 32'd0);

    // N=16, LANES=4, DRAIN_CYC=0.
    done_at1  = -1;
    done_cnt1 = 0;
    start_cyc = cyc;
    for (int s = 0; s < 4; s++)
      for (int bt = 0; bt < 2; bt++) q1.push_back(model(16, 4, 1'b0, s, bt));
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("small_done_cycle", 32'(done_at1), 32'd9);
    chk("small_done_count", 32'(done_cnt1), 32'd1);
    chk("small_queue_empty", 32'(q1.size()), 32'd0);
    for (int s = 0; s < 4; s++)
      for (int x = 0; x < 16; x++)
        chk($sformatf("small_cov_s%0d_addr%0d", s, x), 32'(cov[s][x]), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
